// File: rtl/dcache_if.sv
// Pipeline-side and memory-side signals of the direct-mapped data cache controller.
// The controller attaches through the slave modport; the pipeline/memory environment uses master.
interface dcache_if #(
  parameter int ADDR_W    = 32,
  parameter int LINE_BITS = 128
);
  logic                 MEM_R_EN;
  logic                 MEM_W_EN;
  logic                 is_byte;
  logic [ADDR_W-1:0]    addr;
  logic [31:0]          wdata;
  logic [31:0]          rdata;
  logic                 block_pipe_data_cache;
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [LINE_BITS-1:0] mem_wdata;
  logic [LINE_BITS-1:0] mem_rdata;
  logic                 mem_ack;

  modport slave (
    input  MEM_R_EN, MEM_W_EN, is_byte, addr, wdata, mem_rdata, mem_ack,
    output rdata, block_pipe_data_cache, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output MEM_R_EN, MEM_W_EN, is_byte, addr, wdata, mem_rdata, mem_ack,
    input  rdata, block_pipe_data_cache, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller: hit servicing, dirty writeback, line fill.
// Optional hit/miss counters are compiled in when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
  parameter int NUM_LINES = 4,
  parameter int ADDR_W    = 32,
  parameter int LINE_BITS = 128
) (
  input  logic        clk,
  input  logic        reset,
  dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - 4 - IDX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

  state_t               state_q, state_d;
  logic [LINE_BITS-1:0] data_q [NUM_LINES];
  logic [LINE_BITS-1:0] data_d [NUM_LINES];
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q, valid_d, dirty_q, dirty_d;

  logic                 active, hit, lookup_hit, lookup_miss;
  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag;
  logic [LINE_BITS-1:0] cur_line;
  logic [31:0]          sel_word;
  logic [7:0]           sel_byte;

  logic                 stall, req, we;
  logic [ADDR_W-1:0]    maddr;
  logic [LINE_BITS-1:0] mwdata;

  assign active      = bus.MEM_R_EN | bus.MEM_W_EN;
  assign idx         = bus.addr[4 +: IDX_W];
  assign tag         = bus.addr[ADDR_W-1 -: TAG_W];
  assign hit         = valid_q[idx] && (tag_q[idx] == tag);
  assign lookup_hit  = (state_q == IDLE) && active && hit;
  assign lookup_miss = (state_q == IDLE) && active && !hit;
  assign cur_line    = data_q[idx];
  assign sel_word    = cur_line[{bus.addr[3:2], 5'b0} +: 32];
  assign sel_byte    = cur_line[{bus.addr[3:0], 3'b0} +: 8];

  // Simultaneous read and write enables resolve to a store, so no load data is returned.
  assign bus.rdata = (lookup_hit && bus.MEM_R_EN && !bus.MEM_W_EN)
                     ? (bus.is_byte ? {{24{sel_byte[7]}}, sel_byte} : sel_word)
                     : 32'h0;

  assign bus.block_pipe_data_cache = stall;
  assign bus.mem_req               = req;
  assign bus.mem_we                = we;
  assign bus.mem_addr              = maddr;
  assign bus.mem_wdata             = mwdata;

  always_comb begin
    state_d = state_q;
    stall   = lookup_miss;
    req     = 1'b0;
    we      = 1'b0;
    maddr   = '0;
    mwdata  = '0;
    case (state_q)
      IDLE: begin
        if (lookup_miss)
          state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FILL;
      end
      WRITEBACK: begin
        // Victim address comes from the tag array; the pipeline keeps addr stable.
        stall  = 1'b1;
        req    = 1'b1;
        we     = 1'b1;
        maddr  = {tag_q[idx], idx, 4'b0000};
        mwdata = cur_line;
        if (bus.mem_ack) state_d = FILL;
      end
      FILL: begin
        stall = 1'b1;
        req   = 1'b1;
        maddr = {tag, idx, 4'b0000};
        if (bus.mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (lookup_hit && bus.MEM_W_EN) begin
      if (bus.is_byte)
        data_d[idx][{bus.addr[3:0], 3'b0} +: 8] = bus.wdata[7:0];
      else
        data_d[idx][{bus.addr[3:2], 5'b0} +: 32] = bus.wdata;
      dirty_d[idx] = 1'b1;
    end
    if ((state_q == WRITEBACK) && bus.mem_ack)
      dirty_d[idx] = 1'b0;
    if ((state_q == FILL) && bus.mem_ack) begin
      data_d[idx]  = bus.mem_rdata;
      tag_d[idx]   = tag;
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic        replay_q, replay_d;

  // The first IDLE cycle after a fill is the replayed access and is not a fresh hit.
  always_comb begin
    replay_d   = (state_q == FILL) && bus.mem_ack;
    hit_cnt_d  = hit_cnt_q + {31'b0, (lookup_hit && !replay_q)};
    miss_cnt_d = miss_cnt_q + {31'b0, lookup_miss};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      replay_q   <= replay_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: fill, store/load hits, dirty writeback, reset mid-fill, idle ack.
// Counter checks are compiled in when DCACHE_STATS_EN is defined.
module tb_dcache_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  localparam logic [127:0] LINE1 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_11223344;
  localparam logic [127:0] LINE1_WB = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_11228044;
  localparam logic [127:0] LINE2 = 128'h44444444_33333333_22222222_9ABCDEF0;

  dcache_if #(.ADDR_W(32), .LINE_BITS(128)) bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dcache_ctrl #(.NUM_LINES(4), .ADDR_W(32), .LINE_BITS(128)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic access(input logic r, input logic w, input logic b,
                        input logic [31:0] a, input logic [31:0] d);
    bus.MEM_R_EN = r;
    bus.MEM_W_EN = w;
    bus.is_byte  = b;
    bus.addr     = a;
    bus.wdata    = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    access(0, 0, 0, 32'h0, 32'h0);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    sample();
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", bus.mem_req); end
    total++; if (bus.block_pipe_data_cache !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus.block_pipe_data_cache); end
    total++; if (bus.mem_addr !== 32'h0 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_addr got=%h/%b exp=0/0", bus.mem_addr, bus.mem_we); end
    total++; if (bus.mem_wdata !== 128'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", bus.mem_wdata); end
    total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
`ifdef DCACHE_STATS_EN
    total++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin bad++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", hit_count, miss_count); end
`endif
    tick();
    reset = 1'b1;
  endtask

  task automatic test_fill_load();
    int stalls = 0;
    int reqc = 0;
    logic done = 1'b0;
    tick();
    bus.mem_rdata = LINE1;
    access(1, 0, 0, 32'h50, 32'h0);
    for (int k = 0; k < 20; k++) begin
      sample();
      if (!bus.block_pipe_data_cache) begin
        done = 1'b1;
        break;
      end
      stalls++;
      if (stalls == 1) begin
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL miss_cycle_req got=%b exp=0", bus.mem_req); end
      end
      if (bus.mem_req === 1'b1) begin
        reqc++;
        if (reqc == 1) begin
          total++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h50) begin bad++; $display("FAIL fill_req got=we%b/%h exp=we0/00000050", bus.mem_we, bus.mem_addr); end
        end
      end
      tick();
      bus.mem_ack = (reqc == 2);
    end
    bus.mem_ack = 1'b0;
    total++; if (!done) begin bad++; $display("FAIL fill_timeout got=stalled exp=released"); end
    total++; if (stalls !== 4) begin bad++; $display("FAIL fill_stall_len got=%0d exp=4", stalls); end
    total++; if (bus.rdata !== 32'h11223344 || bus.mem_req !== 1'b0) begin bad++; $display("FAIL fill_replay got=%h/req%b exp=11223344/req0", bus.rdata, bus.mem_req); end
    tick();
    access(1, 0, 0, 32'h5C, 32'h0);
    sample();
    total++; if (bus.rdata !== 32'hDDDDDDDD || bus.block_pipe_data_cache !== 1'b0) begin bad++; $display("FAIL ldw_word3 got=%h/%b exp=dddddddd/0", bus.rdata, bus.block_pipe_data_cache); end
    tick();
    access(1, 0, 0, 32'h53, 32'h0);
    sample();
    total++; if (bus.rdata !== 32'h11223344) begin bad++; $display("FAIL ldw_unaligned got=%h exp=11223344", bus.rdata); end
  endtask

  task automatic test_store_byte();
    tick();
    access(0, 1, 1, 32'h51, 32'hAAAAAA80);
    sample();
    total++; if (bus.block_pipe_data_cache !== 1'b0 || bus.rdata !== 32'h0) begin bad++; $display("FAIL stb_hit got=%b/%h exp=0/0", bus.block_pipe_data_cache, bus.rdata); end
    tick();
    access(1, 0, 1, 32'h51, 32'h0);
    sample();
    total++; if (bus.rdata !== 32'hFFFFFF80 || bus.block_pipe_data_cache !== 1'b0) begin bad++; $display("FAIL ldb_sext got=%h/%b exp=ffffff80/0", bus.rdata, bus.block_pipe_data_cache); end
    tick();
    access(1, 0, 0, 32'h50, 32'h0);
    sample();
    total++; if (bus.rdata !== 32'h11228044) begin bad++; $display("FAIL ldw_after_stb got=%h exp=11228044", bus.rdata); end
    tick();
    access(1, 0, 1, 32'h50, 32'h0);
    sample();
    total++; if (bus.rdata !== 32'h00000044) begin bad++; $display("FAIL ldb_pos got=%h exp=00000044", bus.rdata); end
  endtask

  task automatic test_writeback();
    tick();
    access(1, 0, 0, 32'h90, 32'h0);
    sample();
    total++; if (bus.block_pipe_data_cache !== 1'b1 || bus.mem_req !== 1'b0) begin bad++; $display("FAIL wb_miss got=%b/%b exp=1/0", bus.block_pipe_data_cache, bus.mem_req); end
    tick();
    sample();
    total++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h50) begin bad++; $display("FAIL wb_req got=%b/%b/%h exp=1/1/00000050", bus.mem_req, bus.mem_we, bus.mem_addr); end
    total++; if (bus.mem_wdata !== LINE1_WB || bus.mem_wdata[15:8] !== 8'h80) begin bad++; $display("FAIL wb_data got=%h exp=%h", bus.mem_wdata, LINE1_WB); end
    tick();
    bus.mem_ack = 1'b1;
    sample();
    total++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h50 || bus.block_pipe_data_cache !== 1'b1) begin bad++; $display("FAIL wb_hold got=%b/%b/%h exp=1/1/00000050", bus.mem_req, bus.mem_we, bus.mem_addr); end
    tick();
    bus.mem_ack = 1'b0;
    sample();
    total++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h90 || bus.block_pipe_data_cache !== 1'b1) begin bad++; $display("FAIL wb_fill got=%b/%b/%h exp=1/0/00000090", bus.mem_req, bus.mem_we, bus.mem_addr); end
    tick();
    bus.mem_ack = 1'b1;
    bus.mem_rdata = LINE2;
    sample();
    total++; if (bus.block_pipe_data_cache !== 1'b1) begin bad++; $display("FAIL wb_fill_stall got=%b exp=1", bus.block_pipe_data_cache); end
    tick();
    bus.mem_ack = 1'b0;
    sample();
    total++; if (bus.block_pipe_data_cache !== 1'b0 || bus.rdata !== 32'h9ABCDEF0 || bus.mem_req !== 1'b0) begin bad++; $display("FAIL wb_replay got=%b/%h/%b exp=0/9abcdef0/0", bus.block_pipe_data_cache, bus.rdata, bus.mem_req); end
`ifdef DCACHE_STATS_EN
    total++; if (hit_count !== 32'd6 || miss_count !== 32'd2) begin bad++; $display("FAIL stats_pre_reset got=%0d/%0d exp=6/2", hit_count, miss_count); end
`endif
    tick();
    access(0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_reset_mid_fill();
    tick();
    bus.mem_rdata = LINE1;
    access(1, 0, 0, 32'h50, 32'h0);
    sample();
    total++; if (bus.block_pipe_data_cache !== 1'b1) begin bad++; $display("FAIL rmf_miss got=%b exp=1", bus.block_pipe_data_cache); end
    tick();
    sample();
    total++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h50) begin bad++; $display("FAIL rmf_fill got=%b/%b/%h exp=1/0/00000050", bus.mem_req, bus.mem_we, bus.mem_addr); end
    #2;
    reset = 1'b0;
    access(0, 0, 0, 32'h0, 32'h0);
    #1;
    total++; if (bus.mem_req !== 1'b0 || bus.block_pipe_data_cache !== 1'b0 || bus.mem_addr !== 32'h0) begin bad++; $display("FAIL rmf_async got=%b/%b/%h exp=0/0/0", bus.mem_req, bus.block_pipe_data_cache, bus.mem_addr); end
`ifdef DCACHE_STATS_EN
    total++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin bad++; $display("FAIL rmf_stats got=%0d/%0d exp=0/0", hit_count, miss_count); end
`endif
    tick();
    reset = 1'b1;
    tick();
    access(1, 0, 0, 32'h50, 32'h0);
    sample();
    total++; if (bus.block_pipe_data_cache !== 1'b1) begin bad++; $display("FAIL rmf_remiss got=%b exp=1", bus.block_pipe_data_cache); end
    tick();
    bus.mem_ack = 1'b1;
    sample();
    total++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL rmf_refill got=%b/%b exp=1/0", bus.mem_req, bus.mem_we); end
    tick();
    bus.mem_ack = 1'b0;
    sample();
    total++; if (bus.rdata !== 32'h11223344 || bus.block_pipe_data_cache !== 1'b0) begin bad++; $display("FAIL rmf_replay got=%h/%b exp=11223344/0", bus.rdata, bus.block_pipe_data_cache); end
    tick();
    access(0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_ack_idle_and_rw();
    tick();
    bus.mem_ack = 1'b1;
    sample();
    total++; if (bus.mem_req !== 1'b0 || bus.block_pipe_data_cache !== 1'b0) begin bad++; $display("FAIL idle_ack got=%b/%b exp=0/0", bus.mem_req, bus.block_pipe_data_cache); end
    tick();
    bus.mem_ack = 1'b0;
    access(1, 1, 0, 32'h54, 32'hCAFEF00D);
    sample();
    total++; if (bus.block_pipe_data_cache !== 1'b0 || bus.mem_req !== 1'b0 || bus.rdata !== 32'h0) begin bad++; $display("FAIL rw_store got=%b/%b/%h exp=0/0/0", bus.block_pipe_data_cache, bus.mem_req, bus.rdata); end
    tick();
    access(1, 0, 0, 32'h54, 32'h0);
    sample();
    total++; if (bus.rdata !== 32'hCAFEF00D || bus.block_pipe_data_cache !== 1'b0) begin bad++; $display("FAIL rw_readback got=%h/%b exp=cafef00d/0", bus.rdata, bus.block_pipe_data_cache); end
    tick();
    access(0, 0, 0, 32'h0, 32'h0);
    sample();
`ifdef DCACHE_STATS_EN
    total++; if (hit_count !== 32'd2 || miss_count !== 32'd1) begin bad++; $display("FAIL stats_final got=%0d/%0d exp=2/1", hit_count, miss_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_fill_load();
    test_store_byte();
    test_writeback();
    test_reset_mid_fill();
    test_ack_idle_and_rw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-back data cache controller sitting between the MEM stage and main memory.
- Services pipeline loads and stores (byte and word).
- Drives the block_pipe_data_cache stall that the control unit consumes to freeze the pipeline.
- On a miss it runs an optional dirty-line writeback followed by a line fill, using a req/ack handshake to memory.

Parameters:
NUM_LINES, 4, number of cache lines (power of 2, >=2)
ADDR_W, 32, byte address width
LINE_BITS, 128, line size in bits (16 bytes, fixed)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
MEM_R_EN  in  1  load request this cycle
MEM_W_EN  in  1  store request this cycle
is_byte  in  1  1 = byte access, 0 = word access
addr  in  ADDR_W  byte address
wdata  in  32  store data (byte stores use wdata[7:0])
rdata  out  32  load result, combinational on a hit
block_pipe_data_cache  out  1  stall request to the control unit
mem_req  out  1  memory request
mem_we  out  1  1 = writeback, 0 = fill
mem_addr  out  ADDR_W  line-aligned address (bits [3:0] = 0)
mem_wdata  out  LINE_BITS  victim line data
mem_rdata  in  LINE_BITS  fill data
mem_ack  in  1  memory completion, one-cycle pulse

Behaviour:
- Address split:
  - offset = addr[3:0]
  - index = addr[4+log2(NUM_LINES)-1:4]
  - tag = remaining upper bits
- Word accesses ignore addr[1:0].
- Access is active when MEM_R_EN | MEM_W_EN. If both are set, the access is treated as a store.
- Hit = valid[index] & (tag_mem[index] == tag).
- FSM states: IDLE, WRITEBACK, FILL.
  - IDLE, active access, hit: no stall.
    - Load: rdata = selected word, or the byte sign-extended to 32 bits.
    - Store: byte/word lane updated at the clock edge; dirty[index] set.
  - IDLE, active access, miss: block_pipe_data_cache = 1 in the same cycle.
    - If valid & dirty, next state is WRITEBACK; otherwise next state is FILL.
  - WRITEBACK:
    - mem_req = 1, mem_we = 1.
    - mem_addr = {victim tag, index, 4'b0}; mem_wdata = victim line.
    - On mem_ack: clear dirty, go to FILL.
  - FILL:
    - mem_req = 1, mem_we = 0, mem_addr = {tag, index, 4'b0}.
    - On mem_ack: line <= mem_rdata, tag updated, valid = 1, dirty = 0, go to IDLE.
  - The access is replayed in IDLE and now hits.
- Stall timing:
  - block_pipe_data_cache = 1 whenever state != IDLE, or state == IDLE with an active miss.
  - Clean miss detected in cycle N with ack in cycle M: stall is high for cycles N..M, low at M+1 with the hit data valid.
- Memory handshake:
  - mem_addr, mem_we and mem_wdata are held stable while mem_req = 1.
  - mem_req drops in the cycle after the ack.
  - mem_ack is ignored when mem_req = 0.
- The pipeline holds addr/wdata/enables stable while stalled. The controller does not latch them, except the victim tag/index, which are taken from the arrays.
- rdata = 0 when there is no active load or on a miss.
- Reset (asserted asynchronously at any time, including mid-WRITEBACK/FILL):
  - state = IDLE; all valid and dirty bits cleared; mem_req = 0; mem_we = 0.
  - mem_addr = 0; mem_wdata = 0; block_pipe_data_cache = 0 (no access active).
  - Dirty data is discarded.
  - Data and tag arrays need no reset.

Optional Feature:
DCACHE_STATS_EN
- Defined: adds output ports hit_count[31:0] and miss_count[31:0], both reset to 0.
  - hit_count increments once per access completed without a stall.
  - miss_count increments once per miss, on the IDLE -> WRITEBACK/FILL transition.
  - The replayed hit after a fill counts neither.
  - Counters wrap at 2^32.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then LDW addr 0x50 with mem_rdata line word[0] = 0x11223344 and ack 3 cycles after mem_req -> mem_req = 1, mem_we = 0, mem_addr = 0x50; stall high 4 cycles; next cycle rdata = 0x11223344, stall = 0.
- STB wdata 0x80 at 0x51 (hit), then LDB 0x51 -> no stall; rdata = 0xFFFFFF80; line 1 dirty.
- LDW 0x90 (same index as 0x50, dirty) -> WRITEBACK with mem_we = 1, mem_addr = 0x50, mem_wdata byte 1 = 0x80; then FILL with mem_addr = 0x90; stall held through both acks.
- Assert reset during FILL before ack -> mem_req = 0 and stall = 0 immediately; later LDW 0x50 misses again (valid cleared).
- mem_ack pulsed while idle, and MEM_R_EN & MEM_W_EN both set on a hit -> ack ignored; access performed as a store.
- With DCACHE_STATS_EN, run the scenarios above -> hit_count and miss_count match the expected hit/miss totals; without the macro the bench compiles with no counter ports.
